// File: rtl/lcd_timing_pkg.sv
// Shared line/frame geometry for the LCD timing generator.
// ly_of() applies the line-153 quirk: LY reads 0 once the line is under way.
package lcd_timing_pkg;

   localparam int unsigned LX_LAST    = 113;
   localparam int unsigned LY_LAST    = 153;
   localparam int unsigned LY_VBLANK  = 144;
   localparam int unsigned LX_OAM_END = 20;

   function automatic logic [7:0] ly_of(input logic [7:0] v, input logic [6:0] lx);
      return (v == 8'(LY_LAST) && lx != 7'd0) ? 8'd0 : v;
   endfunction

endpackage

// File: rtl/lcd_wrap_counter.sv
// Up-counter 0..LAST with increment enable, synchronous clear and a wrap flag.
// count_next is exported so the parent can register flags in step with the count.
module lcd_wrap_counter #(
   parameter int WIDTH = 8,
   parameter int LAST  = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] count_next,
   output logic             wrap
);

   assign wrap = inc && !clr && (count == WIDTH'(LAST));

   always_comb begin
      count_next = count;
      if (clr)
         count_next = '0;
      else if (wrap)
         count_next = '0;
      else if (inc)
         count_next = count + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/lcd_line_timing.sv
// Line/frame timing generator: 114 line-steps (228 clk2) per line, 154 lines per frame.
// All status flags are registered from the counters' next values so they align with lx/v.
module lcd_line_timing
   import lcd_timing_pkg::*;
(
   input  logic       clk2,
   input  logic       nreset_video,
   input  logic       ff40_d7,
   input  logic [7:0] lyc,
   output logic [7:0] v,
   output logic [7:0] ly,
   output logic [6:0] lx,
   output logic       line_end,
   output logic       frame_start,
   output logic       vblank,
   output logic       vblank_irq,
   output logic       oam_scan,
   output logic       lyc_match,
   output logic       lyc_irq
);

   logic       phase;
   logic [6:0] lx_next;
   logic [7:0] v_next;
   logic [7:0] ly_next;
   logic       lx_wrap;
   logic       v_wrap;
   logic       match_next;

   lcd_wrap_counter #(.WIDTH(7), .LAST(int'(LX_LAST))) u_lx (
      .clk        (clk2),
      .rst_n      (nreset_video),
      .clr        (!ff40_d7),
      .inc        (phase),
      .count      (lx),
      .count_next (lx_next),
      .wrap       (lx_wrap)
   );

   lcd_wrap_counter #(.WIDTH(8), .LAST(int'(LY_LAST))) u_v (
      .clk        (clk2),
      .rst_n      (nreset_video),
      .clr        (!ff40_d7),
      .inc        (lx_wrap),
      .count      (v),
      .count_next (v_next),
      .wrap       (v_wrap)
   );

   assign ly_next    = ly_of(v_next, lx_next);
   assign match_next = (ly_next == lyc);

   // Disable is a synchronous hold: every flag and the edge detector return to 0.
   always_ff @(posedge clk2 or negedge nreset_video) begin
      if (!nreset_video) begin
         phase       <= 1'b0;
         ly          <= '0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
         vblank      <= 1'b0;
         vblank_irq  <= 1'b0;
         oam_scan    <= 1'b0;
         lyc_match   <= 1'b0;
         lyc_irq     <= 1'b0;
      end else if (!ff40_d7) begin
         phase       <= 1'b0;
         ly          <= '0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
         vblank      <= 1'b0;
         vblank_irq  <= 1'b0;
         oam_scan    <= 1'b0;
         lyc_match   <= 1'b0;
         lyc_irq     <= 1'b0;
      end else begin
         phase       <= ~phase;
         ly          <= ly_next;
         line_end    <= lx_wrap;
         frame_start <= v_wrap;
         vblank      <= (v_next >= 8'(LY_VBLANK));
         vblank_irq  <= lx_wrap && (v_next == 8'(LY_VBLANK));
         oam_scan    <= (v_next < 8'(LY_VBLANK)) && (lx_next < 7'(LX_OAM_END));
         lyc_match   <= match_next;
         lyc_irq     <= match_next && !lyc_match;
      end
   end

endmodule

// File: tb/tb_lcd_line_timing.sv
// Self-checking bench: a cycle-count model pushes expected outputs per edge into a
// scoreboard queue; entries are popped and compared just after each clk2 edge.
module tb_lcd_line_timing;

   typedef struct {
      int lx, v, ly;
      int line_end, frame_start, vblank, vblank_irq, oam_scan, lyc_match, lyc_irq;
   } exp_t;

   logic       clk2 = 1'b0;
   logic       nreset_video;
   logic       ff40_d7;
   logic [7:0] lyc;
   logic [7:0] v, ly;
   logic [6:0] lx;
   logic       line_end, frame_start, vblank, vblank_irq, oam_scan, lyc_match, lyc_irq;

   int errors = 0;
   int checks = 0;
   int n = 0;
   int prev_match = 0;
   exp_t sb[$];

   lcd_line_timing dut (
      .clk2        (clk2),
      .nreset_video(nreset_video),
      .ff40_d7     (ff40_d7),
      .lyc         (lyc),
      .v           (v),
      .ly          (ly),
      .lx          (lx),
      .line_end    (line_end),
      .frame_start (frame_start),
      .vblank      (vblank),
      .vblank_irq  (vblank_irq),
      .oam_scan    (oam_scan),
      .lyc_match   (lyc_match),
      .lyc_irq     (lyc_irq)
   );

   always #5 clk2 = ~clk2;

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at t=%0t n=%0d: got %0d want %0d", tag, $time, n, got, want);
      end
   endtask

   task automatic check_all(input exp_t e);
      check("lx", int'(lx), e.lx);
      check("v", int'(v), e.v);
      check("ly", int'(ly), e.ly);
      check("line_end", int'(line_end), e.line_end);
      check("frame_start", int'(frame_start), e.frame_start);
      check("vblank", int'(vblank), e.vblank);
      check("vblank_irq", int'(vblank_irq), e.vblank_irq);
      check("oam_scan", int'(oam_scan), e.oam_scan);
      check("lyc_match", int'(lyc_match), e.lyc_match);
      check("lyc_irq", int'(lyc_irq), e.lyc_irq);
   endtask

   function automatic exp_t zero_exp();
      exp_t e;
      e = '{default: 0};
      return e;
   endfunction

   // Model: after n enabled edges, lx = (n/2) mod 114, v = (n/228) mod 154.
   task automatic step(input logic en, input logic [7:0] lyc_val);
      exp_t e;
      int f;
      ff40_d7 = en;
      lyc     = lyc_val;
      if (!en) begin
         n = 0;
         prev_match = 0;
         e = zero_exp();
      end else begin
         n++;
         f = n % 35112;
         e.v  = f / 228;
         e.lx = (f % 228) / 2;
         e.ly = (e.v == 153 && e.lx >= 1) ? 0 : e.v;
         e.line_end    = (f % 228 == 0) ? 1 : 0;
         e.frame_start = (f == 0) ? 1 : 0;
         e.vblank      = (e.v >= 144) ? 1 : 0;
         e.vblank_irq  = (f == 144 * 228) ? 1 : 0;
         e.oam_scan    = (e.v < 144 && e.lx < 20) ? 1 : 0;
         e.lyc_match   = (e.ly == int'(lyc_val)) ? 1 : 0;
         e.lyc_irq     = (e.lyc_match == 1 && prev_match == 0) ? 1 : 0;
         prev_match    = e.lyc_match;
      end
      sb.push_back(e);
      @(posedge clk2);
      #1;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         check_all(sb.pop_front());
      end
   endtask

   initial begin
      nreset_video = 1'b0;
      ff40_d7      = 1'b0;
      lyc          = 8'd0;
      repeat (3) @(posedge clk2);
      #1;
      check_all(zero_exp());

      nreset_video = 1'b1;
      step(1'b0, 8'd0);

      // Frame 1 with lyc = 0: irq on first cycle and again in late line 153.
      while (n < 35112 + 2 * 228) step(1'b1, 8'd0);

      // lyc = 10 during frame 2, then drop enable at v = 77, lx = 50.
      while (n < 35112 + 77 * 228 + 100) step(1'b1, 8'd10);
      check("pre_disable_v", int'(v), 77);
      check("pre_disable_lx", int'(lx), 50);
      repeat (3) step(1'b0, 8'd10);

      // Re-enable and run to line 150, then async reset mid-cycle.
      while (n < 150 * 228 + 40) step(1'b1, 8'd150);
      #2;
      nreset_video = 1'b0;
      #1;
      n = 0;
      prev_match = 0;
      check_all(zero_exp());
      repeat (2) @(posedge clk2);
      #1;
      check_all(zero_exp());
      nreset_video = 1'b1;

      while (n < 3 * 228 + 10) step(1'b1, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
